// File: rtl/sha_nonce_dispatch_pkg.sv
// Shared types, widths and helpers for the multi-core nonce dispatcher.
// Also provides the CH_HASH byte-swap macro used for target compares.

`ifndef CH_HASH
`define CH_HASH(h) sha_nonce_dispatch_pkg::ch_hash(h)
`endif

package sha_nonce_dispatch_pkg;

  localparam int unsigned WORD_S    = 32;
  localparam int unsigned H_SIZE    = 256;
  localparam int unsigned MAX_CORES = 16;
  localparam int unsigned PC_W      = $clog2(MAX_CORES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_S-1:0] nonce;
    logic [H_SIZE-1:0] hash;
  } win_t;

  // Reverse byte order of a 256-bit digest (raw H_final -> comparable value).
  function automatic logic [H_SIZE-1:0] ch_hash(input logic [H_SIZE-1:0] h);
    logic [H_SIZE-1:0] r;
    r = '0;
    for (int b = 0; b < int'(H_SIZE / 8); b++) begin
      r[8*b +: 8] = h[H_SIZE-8-8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_CORES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(MAX_CORES); i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sha_result_arbiter.sv
// Per-core target compare and lowest-index hit select, registered.
// One cycle of latency between res_valid and hit/win/cnt.

module sha_result_arbiter
  import sha_nonce_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_CORES-1:0]        res_valid,
  input  logic [WORD_S*NUM_CORES-1:0] res_nonce,
  input  logic [H_SIZE*NUM_CORES-1:0] res_hash,
  input  logic [H_SIZE-1:0]           target,
  output logic                        hit,
  output win_t                        win,
  output logic [PC_W-1:0]             cnt
);

  logic            hit_q, hit_d;
  win_t            win_q, win_d;
  logic [PC_W-1:0] cnt_q, cnt_d;

  // Descending scan so the lowest-index hitting core is written last.
  always_comb begin
    hit_d = 1'b0;
    win_d = '0;
    cnt_d = '0;
    if (en) begin
      cnt_d = popcount(MAX_CORES'(res_valid));
      for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
        if (res_valid[i] && (`CH_HASH(res_hash[H_SIZE*i +: H_SIZE]) < target)) begin
          hit_d       = 1'b1;
          win_d.nonce = res_nonce[WORD_S*i +: WORD_S];
          win_d.hash  = `CH_HASH(res_hash[H_SIZE*i +: H_SIZE]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      hit_q <= hit_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
    end
  end

  assign hit = hit_q;
  assign win = win_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/sha_nonce_dispatch.sv
// Issues a nonce range in batches to NUM_CORES double-SHA pipelines and reports
// the first hash below target. Define SHA_DISPATCH_STATS_EN to enable hash_count.

module sha_nonce_dispatch
  import sha_nonce_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ISSUE_GAP = 33,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned OUT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WORD_S-1:0]           nonce_first,
  input  logic [WORD_S-1:0]           nonce_last,
  input  logic [H_SIZE-1:0]           target,
  output logic [NUM_CORES-1:0]        issue_valid,
  output logic [WORD_S*NUM_CORES-1:0] issue_nonce,
  input  logic [NUM_CORES-1:0]        res_valid,
  input  logic [WORD_S*NUM_CORES-1:0] res_nonce,
  input  logic [H_SIZE*NUM_CORES-1:0] res_hash,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [WORD_S-1:0]           win_nonce,
  output logic [H_SIZE-1:0]           win_hash,
  output logic [WORD_S-1:0]           hash_count
);

  localparam int unsigned BASE_W = WORD_S + 1;

  state_e                      state_q, state_d;
  logic [BASE_W-1:0]           base_q, base_d;
  logic [WORD_S-1:0]           last_q, last_d;
  logic [H_SIZE-1:0]           target_q, target_d;
  logic [CNT_W-1:0]            gap_q, gap_d;
  logic [OUT_W-1:0]            outstanding_q, outstanding_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        found_q, found_d;
  logic [WORD_S-1:0]           win_nonce_q, win_nonce_d;
  logic [H_SIZE-1:0]           win_hash_q, win_hash_d;
  logic [NUM_CORES-1:0]        issue_valid_q, issue_valid_d;
  logic [WORD_S*NUM_CORES-1:0] issue_nonce_q, issue_nonce_d;

  logic                        accept;
  logic                        arb_hit;
  win_t                        arb_win;
  logic [PC_W-1:0]             arb_cnt;
  logic [PC_W-1:0]             issue_cnt;
  logic [PC_W-1:0]             res_cnt;
  logic                        new_hit;
  logic [OUT_W-1:0]            out_next;

  assign accept = (state_q != ST_IDLE);

  sha_result_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (accept),
    .res_valid (res_valid),
    .res_nonce (res_nonce),
    .res_hash  (res_hash),
    .target    (target_q),
    .hit       (arb_hit),
    .win       (arb_win),
    .cnt       (arb_cnt)
  );

  // Arbiter outputs lag res_valid by a cycle; outstanding only reaches zero
  // after the registered count is consumed, so FLUSH never exits early.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    last_d        = last_q;
    target_d      = target_q;
    gap_d         = gap_q;
    outstanding_d = outstanding_q;
    busy_d        = busy_q;
    done_d        = done_q;
    found_d       = found_q;
    win_nonce_d   = win_nonce_q;
    win_hash_d    = win_hash_q;
    issue_valid_d = '0;
    issue_nonce_d = issue_nonce_q;

    res_cnt = accept ? arb_cnt : '0;
    new_hit = accept && arb_hit && !found_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d        = nonce_last;
          target_d      = target;
          base_d        = {1'b0, nonce_first};
          gap_d         = '0;
          outstanding_d = '0;
          done_d        = 1'b0;
          found_d       = 1'b0;
          busy_d        = 1'b1;
          state_d       = (nonce_first > nonce_last) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        gap_d = (gap_q == CNT_W'(ISSUE_GAP - 1)) ? '0 : gap_q + CNT_W'(1);
        if (new_hit) begin
          state_d = ST_FLUSH;
        end else if (gap_q == '0) begin
          for (int i = 0; i < int'(NUM_CORES); i++) begin
            issue_nonce_d[WORD_S*i +: WORD_S] = WORD_S'(base_q + BASE_W'(i));
            issue_valid_d[i] = ((base_q + BASE_W'(i)) <= {1'b0, last_q});
          end
          base_d = base_q + BASE_W'(NUM_CORES);
          if ((base_q + BASE_W'(NUM_CORES)) > {1'b0, last_q}) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    issue_cnt = popcount(MAX_CORES'(issue_valid_d));
    out_next  = outstanding_q + OUT_W'(issue_cnt) - OUT_W'(res_cnt);
    if (accept) begin
      outstanding_d = out_next;
    end

    if (new_hit) begin
      found_d     = 1'b1;
      win_nonce_d = arb_win.nonce;
      win_hash_d  = arb_win.hash;
    end

    if ((state_q == ST_FLUSH) && (out_next == '0)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      last_q        <= '0;
      target_q      <= '0;
      gap_q         <= '0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      win_nonce_q   <= '0;
      win_hash_q    <= '0;
      issue_valid_q <= '0;
      issue_nonce_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      last_q        <= last_d;
      target_q      <= target_d;
      gap_q         <= gap_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      win_nonce_q   <= win_nonce_d;
      win_hash_q    <= win_hash_d;
      issue_valid_q <= issue_valid_d;
      issue_nonce_q <= issue_nonce_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_nonce = issue_nonce_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign win_nonce   = win_nonce_q;
  assign win_hash    = win_hash_q;

`ifdef SHA_DISPATCH_STATS_EN
  localparam int unsigned SUM_W = WORD_S + 1;

  logic [WORD_S-1:0] hash_count_q, hash_count_d;
  logic [SUM_W-1:0]  hash_sum;

  // Saturating count of results accepted in the current run.
  always_comb begin
    hash_sum     = {1'b0, hash_count_q} + SUM_W'(res_cnt);
    hash_count_d = hash_count_q;
    if ((state_q == ST_IDLE) && start) begin
      hash_count_d = '0;
    end else if (hash_sum[WORD_S]) begin
      hash_count_d = '1;
    end else begin
      hash_count_d = hash_sum[WORD_S-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hash_count_q <= '0;
    end else begin
      hash_count_q <= hash_count_d;
    end
  end

  assign hash_count = hash_count_q;
`else
  assign hash_count = '0;
`endif

endmodule
